// File: rtl/axis_drain_pkg.sv
// Shared types and helpers for the AXI-Stream drain sink.
package axis_drain_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } drain_state_e;

    // Sized for the widest bus the drain supports (1024-bit data); callers zero-extend
    // their tkeep and keep only the low $clog2(DSIZE/8)+1 bits of the result.
    localparam int KEEP_MAX_W     = 128;
    localparam int KEEP_CNT_MAX_W = $clog2(KEEP_MAX_W) + 1;

    function automatic logic [KEEP_CNT_MAX_W-1:0] popcount_keep(input logic [KEEP_MAX_W-1:0] keep);
        logic [KEEP_CNT_MAX_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < KEEP_MAX_W; i++) begin
            cnt = cnt + KEEP_CNT_MAX_W'(keep[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/axi_stream_inf.sv
// AXI-Stream bundle shared by masters and slaves in this codebase.
interface axi_stream_inf #(
    parameter int DSIZE = 32
);
    logic               axis_tvalid;
    logic               axis_tready;
    logic [DSIZE-1:0]   axis_tdata;
    logic [DSIZE/8-1:0] axis_tkeep;
    logic               axis_tlast;
    logic               axis_tuser;

    modport master (
        output axis_tvalid,
        input  axis_tready,
        output axis_tdata,
        output axis_tkeep,
        output axis_tlast,
        output axis_tuser
    );

    modport slave (
        input  axis_tvalid,
        output axis_tready,
        input  axis_tdata,
        input  axis_tkeep,
        input  axis_tlast,
        input  axis_tuser
    );
endinterface

// File: rtl/axis_stable_checker.sv
// Flags an AXIS master that changes or withdraws a beat while it is being stalled.
// Only compiled when AXIS_SLAVE_DRAIN_CHK_EN is defined.
`ifdef AXIS_SLAVE_DRAIN_CHK_EN
module axis_stable_checker
    import axis_drain_pkg::*;
#(
    parameter int DSIZE = 32
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               clear,
    input  logic               tvalid,
    input  logic               tready,
    input  logic [DSIZE-1:0]   tdata,
    input  logic [DSIZE/8-1:0] tkeep,
    input  logic               tlast,
    output logic               err_stable
);

    logic               stalled_q;
    logic [DSIZE-1:0]   data_q;
    logic [DSIZE/8-1:0] keep_q;
    logic               last_q;
    logic               violation;

    // The beat offered during a stall must reappear unchanged on the following cycle.
    assign violation = stalled_q &&
                       (!tvalid || (tdata != data_q) || (tkeep != keep_q) || (tlast != last_q));

    always_ff @(posedge clock) begin
        if (rst) begin
            stalled_q <= 1'b0;
            data_q    <= '0;
            keep_q    <= '0;
            last_q    <= 1'b0;
        end else begin
            stalled_q <= tvalid && !tready;
            if (tvalid && !tready) begin
                data_q <= tdata;
                keep_q <= tkeep;
                last_q <= tlast;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst || clear) begin
            err_stable <= 1'b0;
        end else if (violation) begin
            err_stable <= 1'b1;
        end
    end

endmodule
`endif

// File: rtl/axis_slave_drain.sv
// Terminating AXI-Stream sink: accepts and discards beats while counting beats, packets
// and bytes. Define AXIS_SLAVE_DRAIN_CHK_EN to add the sticky stall-stability checker.
module axis_slave_drain
    import axis_drain_pkg::*;
#(
    parameter int DSIZE      = 32,
    parameter int CNT_W      = 32,
    parameter int RDY_PERIOD = 1
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    axi_stream_inf.slave     slaver,
    output logic [CNT_W-1:0] beat_cnt,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] byte_cnt,
    output logic             in_packet,
    output logic             err_stable
);

    localparam int         KEEP_W     = DSIZE / 8;
    localparam int         KEEP_CNT_W = $clog2(KEEP_W) + 1;
    localparam logic [7:0] TICK_LAST  = 8'(RDY_PERIOD - 1);

    logic [7:0]            tick;
    drain_state_e          state_q;
    drain_state_e          state_d;
    logic                  beat;
    logic [KEEP_CNT_W-1:0] byte_inc;

    assign slaver.axis_tready = enable && (tick == 8'd0);
    assign beat               = slaver.axis_tvalid && slaver.axis_tready;
    assign byte_inc           = KEEP_CNT_W'(popcount_keep(KEEP_MAX_W'(slaver.axis_tkeep)));
    assign in_packet          = (state_q == PKT);

    // Free-running throttle; ready is offered only on tick 0 of each period.
    always_ff @(posedge clock) begin
        if (rst) begin
            tick <= '0;
        end else if (tick >= TICK_LAST) begin
            tick <= '0;
        end else begin
            tick <= tick + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Framing follows every accepted beat, even one swallowed by a clear.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (beat && !slaver.axis_tlast) state_d = PKT;
            PKT:     if (beat && slaver.axis_tlast)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst || clear) begin
            beat_cnt <= '0;
            pkt_cnt  <= '0;
            byte_cnt <= '0;
        end else if (beat) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            pkt_cnt  <= pkt_cnt + CNT_W'(slaver.axis_tlast);
            byte_cnt <= byte_cnt + CNT_W'(byte_inc);
        end
    end

`ifdef AXIS_SLAVE_DRAIN_CHK_EN
    axis_stable_checker #(
        .DSIZE(DSIZE)
    ) u_stable_checker (
        .clock      (clock),
        .rst        (rst),
        .clear      (clear),
        .tvalid     (slaver.axis_tvalid),
        .tready     (slaver.axis_tready),
        .tdata      (slaver.axis_tdata),
        .tkeep      (slaver.axis_tkeep),
        .tlast      (slaver.axis_tlast),
        .err_stable (err_stable)
    );

    logic unused_user;
    assign unused_user = slaver.axis_tuser;
`else
    assign err_stable = 1'b0;

    logic unused_stream;
    assign unused_stream = ^{slaver.axis_tdata, slaver.axis_tuser};
`endif

endmodule

// File: tb/tb_axis_slave_drain.sv
// Bench for axis_slave_drain: an always-ready and a 1-in-4 throttled instance share one
// stimulus stream and are compared each cycle against a behavioural model.
`timescale 1ns/1ps
module tb_axis_slave_drain;

    localparam int DSIZE = 32;
    localparam int CNT_W = 32;
    localparam int NDUT  = 2;
`ifdef AXIS_SLAVE_DRAIN_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              rst;
    logic              enable;
    logic              clear;
    logic              tvalid;
    logic              tlast;
    logic              tuser;
    logic [DSIZE-1:0]  tdata;
    logic [DSIZE/8-1:0] tkeep;
    logic [NDUT-1:0]   tready;

    logic [CNT_W-1:0]  beat_f, beat_s, pkt_f, pkt_s, byte_f, byte_s;
    logic              inpkt_f, inpkt_s, err_f, err_s;

    int                checks = 0;
    int                fails  = 0;

    int unsigned       m_cyc   [NDUT];
    logic [CNT_W-1:0]  m_beat  [NDUT];
    logic [CNT_W-1:0]  m_pkt   [NDUT];
    logic [CNT_W-1:0]  m_byte  [NDUT];
    logic              m_inpkt [NDUT];
    logic              m_err   [NDUT];
    logic              m_stall [NDUT];
    logic [DSIZE-1:0]  m_pdata [NDUT];
    logic [DSIZE/8-1:0] m_pkeep [NDUT];
    logic              m_plast [NDUT];

    logic [DSIZE-1:0]  r_data;
    logic [DSIZE/8-1:0] r_keep;
    logic              r_last;

    axi_stream_inf #(.DSIZE(DSIZE)) axis_fast ();
    axi_stream_inf #(.DSIZE(DSIZE)) axis_slow ();

    assign axis_fast.axis_tvalid = tvalid;
    assign axis_fast.axis_tdata  = tdata;
    assign axis_fast.axis_tkeep  = tkeep;
    assign axis_fast.axis_tlast  = tlast;
    assign axis_fast.axis_tuser  = tuser;
    assign axis_slow.axis_tvalid = tvalid;
    assign axis_slow.axis_tdata  = tdata;
    assign axis_slow.axis_tkeep  = tkeep;
    assign axis_slow.axis_tlast  = tlast;
    assign axis_slow.axis_tuser  = tuser;
    assign tready = {axis_slow.axis_tready, axis_fast.axis_tready};

    axis_slave_drain #(.DSIZE(DSIZE), .CNT_W(CNT_W), .RDY_PERIOD(1)) u_dut_fast (
        .clock      (clock),
        .rst        (rst),
        .enable     (enable),
        .clear      (clear),
        .slaver     (axis_fast),
        .beat_cnt   (beat_f),
        .pkt_cnt    (pkt_f),
        .byte_cnt   (byte_f),
        .in_packet  (inpkt_f),
        .err_stable (err_f)
    );

    axis_slave_drain #(.DSIZE(DSIZE), .CNT_W(CNT_W), .RDY_PERIOD(4)) u_dut_slow (
        .clock      (clock),
        .rst        (rst),
        .enable     (enable),
        .clear      (clear),
        .slaver     (axis_slow),
        .beat_cnt   (beat_s),
        .pkt_cnt    (pkt_s),
        .byte_cnt   (byte_s),
        .in_packet  (inpkt_s),
        .err_stable (err_s)
    );

    always #5 clock = ~clock;

    function automatic int periodOf(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic logic readyExp(input int k);
        return enable && ((m_cyc[k] % periodOf(k)) == 0);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic modelReset(input int k);
        m_cyc[k]   = 0;
        m_beat[k]  = '0;
        m_pkt[k]   = '0;
        m_byte[k]  = '0;
        m_inpkt[k] = 1'b0;
        m_err[k]   = 1'b0;
        m_stall[k] = 1'b0;
        m_pdata[k] = '0;
        m_pkeep[k] = '0;
        m_plast[k] = 1'b0;
    endtask

    // Applies the rules of one clock edge to the model, using the inputs held across it.
    task automatic modelStep();
        for (int k = 0; k < NDUT; k++) begin
            logic rdy, acc, viol;
            rdy  = readyExp(k);
            acc  = tvalid && rdy;
            viol = m_stall[k] && (!tvalid || (tdata != m_pdata[k]) ||
                                  (tkeep != m_pkeep[k]) || (tlast != m_plast[k]));
            if (rst) begin
                modelReset(k);
            end else begin
                m_err[k] = clear ? 1'b0 : (m_err[k] | (CHK_EN && viol));
                m_stall[k] = tvalid && !rdy;
                if (tvalid && !rdy) begin
                    m_pdata[k] = tdata;
                    m_pkeep[k] = tkeep;
                    m_plast[k] = tlast;
                end
                if (acc) m_inpkt[k] = !tlast;
                if (clear) begin
                    m_beat[k] = '0;
                    m_pkt[k]  = '0;
                    m_byte[k] = '0;
                end else if (acc) begin
                    m_beat[k] = m_beat[k] + 1;
                    m_pkt[k]  = m_pkt[k] + CNT_W'(tlast);
                    m_byte[k] = m_byte[k] + CNT_W'($countones(tkeep));
                end
                m_cyc[k]++;
            end
        end
    endtask

    task automatic checkDut(input int k, input logic [CNT_W-1:0] b, input logic [CNT_W-1:0] p,
                            input logic [CNT_W-1:0] y, input logic ip, input logic er);
        checkOutput($sformatf("beat_cnt[%0d]", k), b, m_beat[k]);
        checkOutput($sformatf("pkt_cnt[%0d]", k), p, m_pkt[k]);
        checkOutput($sformatf("byte_cnt[%0d]", k), y, m_byte[k]);
        checkOutput($sformatf("in_packet[%0d]", k), ip, m_inpkt[k]);
        checkOutput($sformatf("err_stable[%0d]", k), er, m_err[k]);
    endtask

    // One clock cycle: drive inputs, check tready mid-cycle, then check state after the edge.
    task automatic applyStimulus(input logic v, input logic [DSIZE-1:0] d, input logic [DSIZE/8-1:0] kp,
                                 input logic l, input logic en, input logic clr, input logic rs);
        @(negedge clock);
        tvalid = v;
        tdata  = d;
        tkeep  = kp;
        tlast  = l;
        tuser  = 1'($urandom_range(0, 1));
        enable = en;
        clear  = clr;
        rst    = rs;
        #1;
        if (!rs) begin
            for (int k = 0; k < NDUT; k++) begin
                checkOutput($sformatf("tready[%0d]", k), tready[k], readyExp(k));
            end
        end
        @(posedge clock);
        modelStep();
        #1;
        checkDut(0, beat_f, pkt_f, byte_f, inpkt_f, err_f);
        checkDut(1, beat_s, pkt_s, byte_s, inpkt_s, err_s);
    endtask

    task automatic resetDut();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic sendBeat(input logic [DSIZE/8-1:0] kp, input logic l);
        applyStimulus(1'b1, $urandom, kp, l, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        clear  = 1'b0;
        tvalid = 1'b0;
        tdata  = '0;
        tkeep  = '0;
        tlast  = 1'b0;
        tuser  = 1'b0;
        for (int k = 0; k < NDUT; k++) modelReset(k);

        resetDut();
        resetDut();
        checkOutput("reset_beat", beat_f, 0);
        checkOutput("reset_inpkt", inpkt_s, 0);

        // Packets of 4, 1 and 7 full-keep beats into the always-ready instance.
        resetDut();
        for (int b = 0; b < 4; b++) sendBeat(4'hF, b == 3);
        sendBeat(4'hF, 1'b1);
        for (int b = 0; b < 7; b++) sendBeat(4'hF, b == 6);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("pkts_beat", beat_f, 12);
        checkOutput("pkts_pkt", pkt_f, 3);
        checkOutput("pkts_byte", byte_f, 48);
        checkOutput("pkts_inpkt", inpkt_f, 0);

        // tvalid held for 40 cycles against the 1-in-4 throttle.
        resetDut();
        for (int c = 0; c < 40; c++) applyStimulus(1'b1, 32'h1234_5678, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("throttle_beat", beat_s, 10);
        checkOutput("throttle_inpkt", inpkt_s, 1);

        // Single beat with partial keep.
        resetDut();
        sendBeat(4'b0011, 1'b1);
        checkOutput("keep_byte", byte_f, 2);
        checkOutput("keep_pkt", pkt_f, 1);
        checkOutput("keep_inpkt", inpkt_f, 0);

        // Clear landing on the middle beat of a 3-beat packet.
        resetDut();
        sendBeat(4'hF, 1'b0);
        applyStimulus(1'b1, $urandom, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("clr_beat", beat_f, 0);
        checkOutput("clr_inpkt", inpkt_f, 1);
        sendBeat(4'hF, 1'b1);
        checkOutput("clr_after_beat", beat_f, 1);
        checkOutput("clr_after_pkt", pkt_f, 1);

        // Reset after 2 beats of a 5-beat packet.
        resetDut();
        sendBeat(4'hF, 1'b0);
        sendBeat(4'hF, 1'b0);
        resetDut();
        checkOutput("rstmid_inpkt", inpkt_f, 0);
        checkOutput("rstmid_beat", beat_f, 0);
        for (int b = 0; b < 3; b++) sendBeat(4'hF, b == 2);
        checkOutput("rstmid_after_beat", beat_f, 3);
        checkOutput("rstmid_after_pkt", pkt_f, 1);

        // enable dropped mid-packet.
        resetDut();
        sendBeat(4'hF, 1'b0);
        for (int c = 0; c < 3; c++) applyStimulus(1'b1, 32'hCAFE_0000, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("en_inpkt", inpkt_f, 1);
        checkOutput("en_beat", beat_f, 1);
        sendBeat(4'hF, 1'b1);
        checkOutput("en_close", inpkt_f, 0);

        // Data changing under a stall on the throttled instance.
        resetDut();
        applyStimulus(1'b0, '0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hA5, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h5A, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("stable_set", err_s, 64'(CHK_EN));
        applyStimulus(1'b1, 32'h5A, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h5A, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("stable_sticky", err_s, 64'(CHK_EN));
        applyStimulus(1'b0, '0, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("stable_clear", err_s, 0);

        // Random traffic; the beat is often held so both stable and unstable stalls occur.
        r_data = $urandom;
        r_keep = 4'($urandom);
        r_last = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 1) == 1) begin
                r_data = $urandom;
                r_keep = 4'($urandom);
                r_last = ($urandom_range(0, 3) == 0);
            end
            applyStimulus($urandom_range(0, 3) != 0, r_data, r_keep, r_last,
                          $urandom_range(0, 7) != 0, $urandom_range(0, 31) == 0,
                          $urandom_range(0, 63) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/axis_slave_drain.md
Name: axis_slave_drain

Overview:
- Terminating sink for an AXI-Stream slave port that nothing downstream consumes.
- Accepts and discards beats, keeping wrap-around beat, packet and byte counters.
- Optional programmable back-pressure lets benches and bring-up builds stall the upstream master deterministically.
- Pairs with the empty-master tie-off: that block quiets an unused downstream port; this one terminates an unused upstream port with observability.

Parameters:
- DSIZE, 32, data width; must match the connected interface; tkeep width DSIZE/8.
- CNT_W, 32, width of every counter output.
- RDY_PERIOD, 1, tready asserted 1 cycle in every RDY_PERIOD cycles; 1 means always ready; legal range 1..255.

Ports:
- clock  input  1  sole clock.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  0 forces tready low.
- clear  input  1  synchronous clear of counters and err_stable.
- slaver  axi_stream_inf.slave  -  stream input; uses axis_tvalid, axis_tready (driven), axis_tdata[DSIZE], axis_tkeep[DSIZE/8], axis_tlast; axis_tuser ignored.
- beat_cnt  output  CNT_W  accepted beats.
- pkt_cnt  output  CNT_W  accepted beats with tlast.
- byte_cnt  output  CNT_W  sum of popcount(tkeep) over accepted beats.
- in_packet  output  1  high between a non-last beat and the closing tlast beat.
- err_stable  output  1  sticky AXIS stability violation flag.

Behaviour:
- Interface rule: one clock, clock; reset rst is synchronous and active-high. All state changes on posedge clock.
- Reset values: beat_cnt, pkt_cnt, byte_cnt = 0; in_packet = 0; err_stable = 0; throttle tick = 0; FSM = IDLE.
- Throttle:
  - tick counts 0..RDY_PERIOD-1 free-running and wraps.
  - axis_tready = enable && (tick == 0), combinational from registered tick and the enable input.
  - RDY_PERIOD=1 gives tready = enable.
- Beat accept = axis_tvalid && axis_tready. Counters update on the clock edge after the accept cycle (1-cycle latency); all wrap modulo 2^CNT_W.
- FSM (states IDLE, PKT):
  - IDLE: beat && !tlast -> PKT. beat && tlast -> IDLE (single-beat packet), pkt_cnt+1.
  - PKT: beat && tlast -> IDLE, pkt_cnt+1. Otherwise stay.
  - in_packet = (state == PKT).
- byte_cnt increment = popcount(tkeep), 0..DSIZE/8. tkeep = 0 beats count as a beat with 0 bytes.
- clear coinciding with a beat:
  - clear wins; all counters become 0 and that beat is not counted.
  - The FSM still advances on the beat, so packet framing is preserved.
- enable deasserted mid-packet: tready stays low, the FSM holds PKT, counters hold.
- rst mid-packet: everything returns to reset values; the remainder of the packet is counted as beats, and its tlast beat increments pkt_cnt.

Optional Feature:
- Macro AXIS_SLAVE_DRAIN_CHK_EN.
- Defined:
  - On a stall cycle (tvalid && !tready), register tdata, tkeep and tlast.
  - On the next cycle, set err_stable sticky if tvalid dropped or any registered field differs.
  - Cleared only by rst or clear.
- Undefined: err_stable is tied 0 and no stall registers are synthesized.

Decomposition:
- Package axis_drain_pkg holds:
  - state enum drain_state_e {IDLE, PKT};
  - function popcount_keep(keep) returning $clog2(DSIZE/8)+1 bits.
- One sub-module, axis_stable_checker (stall capture/compare logic), instantiated only under AXIS_SLAVE_DRAIN_CHK_EN.

Test Plan:
- Always ready, RDY_PERIOD=1: 3 packets of 4, 1, 7 beats, tkeep='1, DSIZE=32 -> beat_cnt=12, pkt_cnt=3, byte_cnt=48, in_packet=0 at end.
- Throttle: RDY_PERIOD=4 with tvalid held high for 40 cycles -> tready high on cycles 0, 4, 8, …; beat_cnt=10.
- Partial keep: single beat with tkeep=4'b0011, tlast=1 -> byte_cnt+2, pkt_cnt+1, FSM stays IDLE.
- Clear/beat collision: clear asserted in the same cycle as the 2nd beat of a 3-beat packet -> counters 0 after that edge; after the 3rd beat, beat_cnt=1, pkt_cnt=1.
- Reset mid-packet: rst after 2 beats of a 5-beat packet -> in_packet=0 and counters 0; the remaining 3 beats give beat_cnt=3, pkt_cnt=1.
- CHK_EN: tvalid high with tready low, then tdata changes 0xA5->0x5A while still stalled -> err_stable=1 next cycle and stays 1 until clear.
